// File: rtl/lc3_pkg.sv
// LC3 memory-stage shared definitions: opcodes, opcode classifiers and the
// memory-access FSM state type.
package lc3_pkg;

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_STI = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    IND  = 2'b01,
    RD   = 2'b10,
    WR   = 2'b11
  } mem_state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  function automatic logic is_indirect(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Ack watchdog for the memory stage: counts unacknowledged request cycles and
// flags expiry on the LIMIT-th one. Only instantiated under MEM_TIMEOUT_EN.
module mem_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic req_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire_o = req_i && !ack_i && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || ack_i || expire_o) begin
      cnt_d = '0;
    end else if (req_i) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access.sv
// LC3 memory-access stage: runs loads/stores (incl. indirect) over a req/ack
// handshake. Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access
  import lc3_pkg::*;
#(
  parameter int unsigned AW             = 16,
  parameter int unsigned DW             = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [15:0]   IR_Exec,
  input  logic [AW-1:0] pcout,
  input  logic [DW-1:0] M_Data,
  input  logic [DW-1:0] Data_dout,
  input  logic          Data_ack,
  output logic          Data_req,
  output logic          Data_rd,
  output logic [AW-1:0] Data_addr,
  output logic [DW-1:0] Data_din,
  output logic [DW-1:0] memout,
  output logic          mem_valid,
  output logic [2:0]    mem_dr,
  output logic          mem_busy,
  output logic          mem_err
);

  mem_state_t    state_q;
  logic          data_req_q;
  logic          data_rd_q;
  logic [AW-1:0] data_addr_q;
  logic [DW-1:0] data_din_q;
  logic [DW-1:0] memout_q;
  logic          mem_valid_q;
  logic [2:0]    mem_dr_q;
  logic [2:0]    dr_q;
  logic          ind_load_q;

  logic [3:0]    op_s;
  logic          accept_s;
  logic          expire_s;
  logic          unused_s;

  assign op_s     = IR_Exec[15:12];
  assign accept_s = (state_q == IDLE) && ex_valid;
  assign unused_s = ^{IR_Exec[8:0], (TIMEOUT_CYCLES != 32'd0)};

`ifdef MEM_TIMEOUT_EN
  logic mem_err_q;

  mem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept_s),
    .req_i    (data_req_q),
    .ack_i    (Data_ack),
    .expire_o (expire_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= mem_err_q | expire_s;
    end
  end

  assign mem_err = mem_err_q;
`else
  assign expire_s = 1'b0;
  assign mem_err  = 1'b0;
`endif

  // Ack is only examined outside IDLE, where Data_req is always held high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_req_q  <= 1'b0;
      data_rd_q   <= 1'b0;
      data_addr_q <= '0;
      data_din_q  <= '0;
      memout_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_dr_q    <= 3'd0;
      dr_q        <= 3'd0;
      ind_load_q  <= 1'b0;
    end else begin
      mem_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid) begin
            data_addr_q <= pcout;
            dr_q        <= IR_Exec[11:9];
            ind_load_q  <= is_load(op_s);
            if (is_store(op_s)) begin
              data_din_q <= M_Data;
            end
            if (is_indirect(op_s)) begin
              state_q    <= IND;
              data_req_q <= 1'b1;
              data_rd_q  <= 1'b1;
            end else if (is_load(op_s)) begin
              state_q    <= RD;
              data_req_q <= 1'b1;
              data_rd_q  <= 1'b1;
            end else if (is_store(op_s)) begin
              state_q    <= WR;
              data_req_q <= 1'b1;
              data_rd_q  <= 1'b0;
            end else begin
              mem_valid_q <= 1'b1;
              memout_q    <= '0;
              mem_dr_q    <= 3'd0;
            end
          end
        end
        IND: begin
          if (expire_s) begin
            state_q    <= IDLE;
            data_req_q <= 1'b0;
          end else if (Data_ack) begin
            data_addr_q <= AW'(Data_dout);
            state_q     <= ind_load_q ? RD : WR;
            data_rd_q   <= ind_load_q;
          end
        end
        RD: begin
          if (expire_s) begin
            state_q    <= IDLE;
            data_req_q <= 1'b0;
          end else if (Data_ack) begin
            memout_q    <= Data_dout;
            mem_dr_q    <= dr_q;
            mem_valid_q <= 1'b1;
            data_req_q  <= 1'b0;
            state_q     <= IDLE;
          end
        end
        WR: begin
          if (expire_s) begin
            state_q    <= IDLE;
            data_req_q <= 1'b0;
          end else if (Data_ack) begin
            memout_q    <= '0;
            mem_dr_q    <= 3'd0;
            mem_valid_q <= 1'b1;
            data_req_q  <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          data_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign Data_req  = data_req_q;
  assign Data_rd   = data_rd_q;
  assign Data_addr = data_addr_q;
  assign Data_din  = data_din_q;
  assign memout    = memout_q;
  assign mem_valid = mem_valid_q;
  assign mem_dr    = mem_dr_q;
  assign mem_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: the bench plays the data memory and
// predicts every request, result and latency from the opcode rules.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [15:0] IR_Exec;
  logic [15:0] pcout;
  logic [15:0] M_Data;
  logic [15:0] Data_dout;
  logic        Data_ack;
  logic        Data_req;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [15:0] memout;
  logic        mem_valid;
  logic [2:0]  mem_dr;
  logic        mem_busy;
  logic        mem_err;

  int errors = 0;
  int checks = 0;
  int noise_mode = 0;
  logic [15:0] mem [logic [15:0]];

  always #5 clk = ~clk;

  mem_access dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .IR_Exec   (IR_Exec),
    .pcout     (pcout),
    .M_Data    (M_Data),
    .Data_dout (Data_dout),
    .Data_ack  (Data_ack),
    .Data_req  (Data_req),
    .Data_rd   (Data_rd),
    .Data_addr (Data_addr),
    .Data_din  (Data_din),
    .memout    (memout),
    .mem_valid (mem_valid),
    .mem_dr    (mem_dr),
    .mem_busy  (mem_busy),
    .mem_err   (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd_mem(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Execute keeps presenting traffic while the stage is busy; it must be ignored.
  task automatic noise();
    if (noise_mode == 1) begin
      ex_valid = 1'b1;
      IR_Exec  = 16'h1261;
    end else begin
      ex_valid = 1'($urandom_range(0, 1));
      IR_Exec  = 16'($urandom);
    end
    pcout  = 16'($urandom);
    M_Data = 16'($urandom);
  endtask

  task automatic access(input logic [15:0] a, input logic rd, input logic [15:0] din,
                        input int w, output logic [15:0] rdata, inout int n);
    for (int i = 0; i < w; i++) begin
      chk("wait_req", Data_req, 1);
      chk("wait_addr", Data_addr, a);
      chk("wait_rd", Data_rd, rd);
      chk("wait_busy", mem_busy, 1);
      chk("wait_valid", mem_valid, 0);
      if (!rd) chk("wait_din", Data_din, din);
      Data_ack  = 1'b0;
      Data_dout = 16'($urandom);
      noise();
      step();
      n++;
    end
    chk("ack_req", Data_req, 1);
    chk("ack_addr", Data_addr, a);
    chk("ack_rd", Data_rd, rd);
    chk("ack_busy", mem_busy, 1);
    chk("ack_valid", mem_valid, 0);
    if (!rd) chk("ack_din", Data_din, din);
    Data_ack = 1'b1;
    if (rd) begin
      rdata     = rd_mem(a);
      Data_dout = rdata;
    end else begin
      mem[a]    = din;
      rdata     = 16'h0000;
      Data_dout = 16'($urandom);
    end
    noise();
    step();
    n++;
    Data_ack = 1'b0;
  endtask

  task automatic do_txn(input logic [15:0] ir, input logic [15:0] pc, input logic [15:0] md,
                        input int w1, input int w2);
    logic [3:0]  op;
    logic        ld, st, ind;
    logic [15:0] a, rdata;
    int          n, exp_lat;
    op  = ir[15:12];
    ld  = (op == 4'h2) || (op == 4'h6) || (op == 4'hA);
    st  = (op == 4'h3) || (op == 4'h7) || (op == 4'hB);
    ind = (op == 4'hA) || (op == 4'hB);
    @(negedge clk);
    ex_valid = 1'b1;
    IR_Exec  = ir;
    pcout    = pc;
    M_Data   = md;
    Data_ack = 1'($urandom_range(0, 1));
    step();
    n = 1;
    ex_valid = 1'b0;
    Data_ack = 1'b0;
    if (!ld && !st) begin
      chk("nop_valid", mem_valid, 1);
      chk("nop_memout", memout, 0);
      chk("nop_dr", mem_dr, 0);
      chk("nop_busy", mem_busy, 0);
      chk("nop_req", Data_req, 0);
    end else begin
      a = pc;
      if (ind) begin
        access(a, 1'b1, 16'h0000, w1, rdata, n);
        a = rdata;
      end
      access(a, ld, md, ind ? w2 : w1, rdata, n);
      ex_valid = 1'b0;
      exp_lat = (ind ? 3 : 2) + w1 + (ind ? w2 : 0);
      chk("latency", n, exp_lat);
      chk("done_valid", mem_valid, 1);
      chk("done_memout", memout, ld ? rdata : 16'h0000);
      chk("done_dr", mem_dr, ld ? 32'(ir[11:9]) : 32'd0);
      chk("done_req", Data_req, 0);
      chk("done_busy", mem_busy, 0);
    end
    chk("no_err", mem_err, 0);
  endtask

  initial begin
    logic [3:0] ops [10];
    logic [15:0] ir, pc;
    ops = '{4'h2, 4'h6, 4'hA, 4'h3, 4'h7, 4'hB, 4'h1, 4'h5, 4'h0, 4'hF};
    rst = 1'b1; ex_valid = 1'b0; IR_Exec = '0; pcout = '0; M_Data = '0;
    Data_dout = '0; Data_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", Data_req, 0);
    chk("rst_rd", Data_rd, 0);
    chk("rst_addr", Data_addr, 0);
    chk("rst_din", Data_din, 0);
    chk("rst_memout", memout, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_dr", mem_dr, 0);
    chk("rst_busy", mem_busy, 0);
    chk("rst_err", mem_err, 0);
    @(negedge clk);
    rst = 1'b0;
    Data_ack = 1'b1;
    Data_dout = 16'hDEAD;
    step();
    chk("stray_ack_req", Data_req, 0);
    chk("stray_ack_valid", mem_valid, 0);
    chk("stray_ack_busy", mem_busy, 0);
    Data_ack = 1'b0;

    mem[16'h3010] = 16'hBEEF;
    do_txn(16'h2405, 16'h3010, 16'h0000, 0, 0);
    chk("ld_beef", memout, 16'hBEEF);
    mem[16'h4000] = 16'h5000;
    do_txn(16'hB60A, 16'h4000, 16'h1234, 0, 0);
    do_txn(16'hA805, 16'h1000, 16'h0000, 3, 3);
    noise_mode = 1;
    do_txn(16'h2405, 16'h2000, 16'h0000, 2, 0);
    noise_mode = 0;
    do_txn(16'h1261, 16'h0000, 16'h0000, 0, 0);
    do_txn(16'h6E3F, 16'hFFFF, 16'h0000, 1, 0);
    do_txn(16'h7C00, 16'hFFFF, 16'hA5A5, 0, 0);
    mem[16'h0000] = 16'hFFFF;
    do_txn(16'hA200, 16'h0000, 16'h0000, 1, 0);
    chk("ldi_ffff", memout, 16'hA5A5);

    for (int t = 0; t < 60; t++) begin
      ir = 16'($urandom);
      ir[15:12] = ops[$urandom_range(0, 9)];
      pc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 63));
      do_txn(ir, pc, 16'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
    end

    // Reset in the middle of a read, then a late ack.
    @(negedge clk);
    ex_valid = 1'b1; IR_Exec = 16'h2405; pcout = 16'h1234;
    step();
    ex_valid = 1'b0;
    chk("mid_req", Data_req, 1);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_req", Data_req, 0);
    chk("mid_rst_busy", mem_busy, 0);
    chk("mid_rst_valid", mem_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    Data_ack = 1'b1; Data_dout = 16'h7777;
    step();
    chk("late_ack_req", Data_req, 0);
    chk("late_ack_valid", mem_valid, 0);
    Data_ack = 1'b0;
    step();
    chk("late_ack_valid2", mem_valid, 0);
    chk("late_ack_busy", mem_busy, 0);

`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    ex_valid = 1'b1; IR_Exec = 16'h2405; pcout = 16'h7777;
    step();
    ex_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_req", Data_req, 1);
      chk("to_err_low", mem_err, 0);
      step();
    end
    chk("to_abort_req", Data_req, 0);
    chk("to_abort_busy", mem_busy, 0);
    chk("to_abort_valid", mem_valid, 0);
    chk("to_err", mem_err, 1);
    step();
    chk("to_err_sticky", mem_err, 1);
`else
    chk("err_tied", mem_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
